// File: rtl/common_pkg.sv
// common: shared core types plus the store buffer entry struct.
package common;
  localparam int n_threads = 4;
  typedef logic [31:0] pptr_t;
  typedef logic [31:0] word_t;
  typedef logic [$clog2(n_threads)-1:0] threadid_t;
  typedef struct packed {
    logic      valid;
    threadid_t thread;
    pptr_t     addr;
    word_t     data;
    logic      isbyte;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match: youngest-first word-address match over the entry array.
module store_buffer_match
  import common::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  pptr_t            addr [DEPTH],
  input  logic [AW-1:0]    tail,
  input  pptr_t            ld_addr,
  output logic             hit,
  output logic [AW-1:0]    idx
);
  logic [AW-1:0] i;
  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    i = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      i = tail - AW'(k);
      if (valid[i] && ((addr[i] ^ ld_addr) & ~pptr_t'(3)) == '0) begin
        hit = 1'b1;
        idx = i;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: committed-store FIFO with load lookup; define STORE_BUFFER_FWD_EN
// to forward word data, otherwise every match stalls the load.
module store_buffer
  import common::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_en,
  input  threadid_t            push_thread,
  input  pptr_t                push_addr,
  input  word_t                push_data,
  input  logic                 push_isbyte,
  output logic                 full,
  output logic                 store_en,
  output logic                 store_isbyte,
  output pptr_t                store_addr,
  output word_t                store_data,
  input  logic                 store_ack,
  input  logic                 ld_en,
  input  pptr_t                ld_addr,
  output logic                 fwd_hit,
  output word_t                fwd_data,
  output logic                 fwd_stall,
  output logic [n_threads-1:0] pending
);
  sb_entry_t ent [DEPTH];
  logic [AW-1:0] head, tail, idx;
  logic [AW:0] count;
  logic [DEPTH-1:0] evalid;
  pptr_t eaddr [DEPTH];
  logic hit, push_ok, pop;
  assign full = count == (AW+1)'(DEPTH);
  assign store_en = count != '0;
  assign store_isbyte = ent[head].isbyte;
  assign store_addr = ent[head].addr;
  assign store_data = ent[head].data;
  assign push_ok = push_en & ~full;
  assign pop = store_en & store_ack;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) ent[k].valid <= 1'b0;
    end else begin
      if (push_ok) begin
        ent[tail] <= '{valid: 1'b1, thread: push_thread, addr: push_addr, data: push_data, isbyte: push_isbyte};
        tail <= tail + 1'b1;
      end
      if (pop) begin
        ent[head].valid <= 1'b0;
        head <= head + 1'b1;
      end
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      evalid[k] = ent[k].valid;
      eaddr[k] = ent[k].addr;
      if (ent[k].valid) pending[ent[k].thread] = 1'b1;
    end
  end
  store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .valid(evalid), .addr(eaddr), .tail(tail), .ld_addr(ld_addr), .hit(hit), .idx(idx)
  );
`ifdef STORE_BUFFER_FWD_EN
  assign fwd_hit = ld_en & hit & ~ent[idx].isbyte;
  assign fwd_data = fwd_hit ? ent[idx].data : '0;
  assign fwd_stall = ld_en & hit & ent[idx].isbyte;
`else
  logic unused_idx;
  assign unused_idx = ^idx;
  assign fwd_hit = 1'b0;
  assign fwd_data = '0;
  assign fwd_stall = ld_en & hit;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of push/drain, full, lookup, pending and reset.
module tb_store_buffer;
  import common::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic push_en = 0, push_isbyte = 0, store_ack = 0, ld_en = 0;
  threadid_t push_thread = '0;
  pptr_t push_addr = '0, ld_addr = '0, store_addr;
  word_t push_data = '0, store_data, fwd_data;
  logic full, store_en, store_isbyte, fwd_hit, fwd_stall;
  logic [n_threads-1:0] pending;
  int total = 0, passed = 0;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_en(push_en), .push_thread(push_thread), .push_addr(push_addr),
    .push_data(push_data), .push_isbyte(push_isbyte), .full(full), .store_en(store_en),
    .store_isbyte(store_isbyte), .store_addr(store_addr), .store_data(store_data),
    .store_ack(store_ack), .ld_en(ld_en), .ld_addr(ld_addr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .fwd_stall(fwd_stall), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input pptr_t a, input word_t d, input logic b, input threadid_t t);
    push_en = 1; push_addr = a; push_data = d; push_isbyte = b; push_thread = t;
  endtask

  task automatic look(input pptr_t a);
    ld_en = 1; ld_addr = a;
    #1;
  endtask

  initial begin
    step(); step();
    rst = 0;
    chk("rst_full", 32'(full), 0);
    chk("rst_store_en", 32'(store_en), 0);
    chk("rst_pending", 32'(pending), 0);
    look(32'h0);
    chk("rst_fwd_hit", 32'(fwd_hit), 0);
    chk("rst_fwd_stall", 32'(fwd_stall), 0);
    ld_en = 0;
    push(32'h1000, 32'hDEADBEEF, 0, 2'd0);
    #1 chk("push_same_cycle_invisible", 32'(store_en), 0);
    step(); push_en = 0;
    chk("t1_store_en", 32'(store_en), 1);
    chk("t1_store_addr", store_addr, 32'h1000);
    chk("t1_store_data", store_data, 32'hDEADBEEF);
    chk("t1_isbyte", 32'(store_isbyte), 0);
    chk("t1_pending", 32'(pending), 32'b0001);
    store_ack = 1; step(); store_ack = 0;
    chk("t1_drained", 32'(store_en), 0);
    chk("t1_pending_clr", 32'(pending), 0);
    for (int k = 0; k < DEPTH; k++) begin
      push(32'h100 + 32'(4 * k), 32'(k), 0, 2'd1);
      step();
      chk("fill_full", 32'(full), (k == DEPTH - 1) ? 1 : 0);
    end
    push(32'h200, 32'h99, 0, 2'd1); store_ack = 1;
    #1 chk("full_during_push_pop", 32'(full), 1);
    step(); push_en = 0; store_ack = 0;
    chk("dropped_push_head", store_addr, 32'h104);
    chk("after_pop_not_full", 32'(full), 0);
    for (int k = 1; k < DEPTH; k++) begin
      chk("drain_addr", store_addr, 32'h100 + 32'(4 * k));
      store_ack = 1; step(); store_ack = 0;
    end
    chk("dropped_push_absent", 32'(store_en), 0);
    push(32'h2000, 32'h11111111, 0, 2'd0); step();
    push(32'h2000, 32'h22222222, 0, 2'd0); step(); push_en = 0;
    look(32'h2000);
    chk("word_fwd_hit", 32'(fwd_hit), FWD ? 1 : 0);
    chk("word_fwd_data", fwd_data, FWD ? 32'h22222222 : 0);
    chk("word_fwd_stall", 32'(fwd_stall), FWD ? 0 : 1);
    look(32'h2002);
    chk("word_offset_hit", 32'(fwd_hit), FWD ? 1 : 0);
    ld_en = 0; #1;
    chk("ld_off_hit", 32'(fwd_hit), 0);
    chk("ld_off_stall", 32'(fwd_stall), 0);
    store_ack = 1; step(); step(); store_ack = 0;
    chk("t3_empty", 32'(store_en), 0);
    push(32'h3001, 32'hAB, 1, 2'd0); step(); push_en = 0;
    chk("byte_head_isbyte", 32'(store_isbyte), 1);
    look(32'h3000);
    chk("byte_stall", 32'(fwd_stall), 1);
    chk("byte_no_hit", 32'(fwd_hit), 0);
    look(32'h3004);
    chk("other_word_stall", 32'(fwd_stall), 0);
    chk("other_word_hit", 32'(fwd_hit), 0);
    push(32'h3000, 32'h55, 0, 2'd0); step(); push_en = 0;
    look(32'h3000);
    chk("youngest_word_hit", 32'(fwd_hit), FWD ? 1 : 0);
    chk("youngest_word_data", fwd_data, FWD ? 32'h55 : 0);
    chk("youngest_word_stall", 32'(fwd_stall), FWD ? 0 : 1);
    ld_en = 0;
    store_ack = 1; step(); step(); store_ack = 0;
    push(32'h5000, 32'h7, 0, 2'd2);
    #1 chk("pending_before", 32'(pending), 0);
    step(); push_en = 0;
    chk("pending_set", 32'(pending), 32'b0100);
    store_ack = 1; step(); store_ack = 0;
    chk("pending_clr", 32'(pending), 0);
    for (int k = 0; k < 3; k++) begin
      push(32'h6000 + 32'(4 * k), 32'(k), 0, 2'(k)); step();
    end
    push_en = 0;
    chk("pre_rst_pending", 32'(pending), 32'b0111);
    rst = 1; store_ack = 1; step(); rst = 0; store_ack = 0;
    chk("mid_rst_store_en", 32'(store_en), 0);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    look(32'h6000);
    chk("mid_rst_lookup", 32'(fwd_hit | fwd_stall), 0);
    ld_en = 0;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      push(32'h7000 + 32'(4 * k), 32'hA0 + 32'(k), 0, 2'd3); step(); push_en = 0;
      chk("wrap_addr", store_addr, 32'h7000 + 32'(4 * k));
      chk("wrap_data", store_data, 32'hA0 + 32'(k));
      store_ack = 1; step(); store_ack = 0;
      chk("wrap_empty", 32'(store_en), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
